shift_pipe: RTL and testbench
=============================

// Module: shift_pipe
// PURPOSE
//   Parametrised, enable-gated delay line; generalises the fixed 2-stage 1-bit register chain.
//   Delays a WIDTH-bit word by DEPTH enabled clock cycles.
//   Carries a per-stage valid bit, supports a synchronous flush and exposes one selectable tap.
//   Used in datapaths and testbench fixtures to align signals across pipeline stages.
// PARAMETERS
//   WIDTH  default 1  data width in bits (>=1)
//   DEPTH  default 2  number of register stages (>=1); DEPTH=2, WIDTH=1 gives a plain 2-stage chain
//   TW     localparam = (DEPTH>1) ? $clog2(DEPTH) : 1; width of tap_sel
//   FW     localparam = $clog2(DEPTH+1); width of fill
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   en         in   1      shift enable; when low all stages hold
//   flush      in   1      synchronous clear of all valid bits
//   din        in   WIDTH  data into stage 0
//   din_valid  in   1      valid tag for din
//   tap_sel    in   TW     index of the stage driven onto tap_out
//   dout       out  WIDTH  stage[DEPTH-1]
//   dout_valid out  1      vld[DEPTH-1]
//   tap_out    out  WIDTH  stage[tap_sel] (combinational mux)
//   tap_valid  out  1      vld[tap_sel]
//   fill       out  FW     number of valid stages; present only with SHIFT_FILL_CNT_EN
// BEHAVIOUR
//   - Reset (async, any time, including mid-shift): all stage[i] and vld[i] = 0 immediately.
//     dout=0, dout_valid=0, tap_out=0, tap_valid=0, fill=0. Nothing is retained across reset.
//   - Edge with en=1, flush=0:
//     stage[0]<=din, vld[0]<=din_valid; stage[i]<=stage[i-1], vld[i]<=vld[i-1] for i>=1.
//   - Edge with en=0, flush=0: every stage and valid bit holds its value.
//   - Edge with flush=1: every vld[i] <= 0, regardless of en.
//     Data regs shift if en=1, otherwise they hold. din_valid on that edge is discarded.
//   - Latency: a word accepted on enabled edge N appears on dout after DEPTH enabled edges.
//     With en held high this is exactly DEPTH cycles. Disabled cycles stretch latency; no word is dropped.
//   - Data always shifts when en=1 whether or not the word is valid; valid bits only tag the data.
//   - Tap: tap_sel in 0..DEPTH-1 selects that stage. tap_sel>=DEPTH gives tap_out=0, tap_valid=0.
//     tap_sel=DEPTH-1 mirrors dout/dout_valid.
//   - DEPTH=1: single register; tap_sel is ignored (treated as 0).
//   - All outputs except tap_out and tap_valid come straight from registers; there is no comb path din->dout.
// CONFIGURATION
//   SHIFT_FILL_CNT_EN defined:
//     - Adds registered output fill = popcount(vld) after each edge.
//     - Update rule on an edge: flush -> 0; else en -> fill + din_valid - vld[DEPTH-1]; else hold.
//     - fill never exceeds DEPTH and never underflows. Reset -> 0.
//   SHIFT_FILL_CNT_EN undefined:
//     - Port fill and its counter logic do not exist. All other behaviour is identical.
// TESTING
//   1. WIDTH=1, DEPTH=2, en=1, din sequence 1,0,1,1 -> dout = 0,0,1,0,1,1.
//      Each stage matches the legacy b/c chain every cycle.
//   2. WIDTH=8, DEPTH=4, en=1, din=0x11,0x22,0x33,0x44 all valid
//      -> dout=0x11 with dout_valid=1 on the 4th edge after 0x11 was accepted.
//      fill=4 once all are in (macro on).
//   3. DEPTH=4: apply en=0 for 3 cycles mid-stream
//      -> dout and tap_out frozen; the first word still emerges after exactly 4 enabled edges.
//   4. DEPTH=4, pipe full of valid data, flush=1 with en=1 and din_valid=1
//      -> all vld=0, dout_valid=0, fill=0 on the next cycle. Data on dout keeps shifting.
//   5. tap_sel swept 0..3 then 5 (DEPTH=4)
//      -> tap_out equals stage[i] for 0..3; tap_out=0, tap_valid=0 for 5.
//   6. Assert reset asynchronously between edges with the pipe full
//      -> all outputs 0 before the next clk edge. After release, first valid din exits DEPTH edges later.

Source files
------------

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - enable-gated WIDTH x DEPTH delay line with per-stage valid tags and one selectable tap
// Optional occupancy counter output "fill" is built when SHIFT_FILL_CNT_EN is defined.
module shift_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] tap_out,
  output logic             tap_valid
`ifdef SHIFT_FILL_CNT_EN
  ,
  output logic [FW-1:0]    fill
`endif
);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] vld;

  // Data moves on every enabled edge; flush only clears the valid tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      vld <= '0;
    end else begin
      if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
      if (flush) begin
        vld <= '0;
      end else if (en) begin
        vld[0] <= din_valid;
        for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
    end
  end

  assign dout       = stage[DEPTH-1];
  assign dout_valid = vld[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_single
      logic unused_tap_sel;
      assign unused_tap_sel = ^tap_sel;
      assign tap_out        = stage[0];
      assign tap_valid      = vld[0];
    end else begin : g_multi
      // Out-of-range selects read as an empty, invalid stage.
      always_comb begin
        tap_out   = '0;
        tap_valid = 1'b0;
        if (32'(tap_sel) < DEPTH) begin
          tap_out   = stage[tap_sel];
          tap_valid = vld[tap_sel];
        end
      end
    end
  endgenerate

`ifdef SHIFT_FILL_CNT_EN
  // Tracks popcount(vld) incrementally: one word in at stage 0, one out of the last stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= '0;
    end else if (flush) begin
      fill <= '0;
    end else if (en) begin
      fill <= fill + FW'(din_valid) - FW'(vld[DEPTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - self-checking bench for shift_pipe (history-queue model plus directed literal checks)
module tb_shift_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en = 1'b0, flush = 1'b0, din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] tap_sel = 2'd0;

  logic [7:0] dout4, tap4;
  logic       dv4, tv4;
  logic [3:0] dout3, tap3;
  logic       dv3, tv3;
  logic       d2 = 1'b0, tsel2 = 1'b0;
  logic       dout2, dv2, tap2, tv2;
`ifdef SHIFT_FILL_CNT_EN
  logic [2:0] fill4;
  logic [1:0] fill3, fill2;
`endif

  shift_pipe #(.WIDTH(8), .DEPTH(4)) u_p4 (
    .clk(clk), .reset(rst), .en(en), .flush(flush), .din(din), .din_valid(din_valid),
    .tap_sel(tap_sel), .dout(dout4), .dout_valid(dv4), .tap_out(tap4), .tap_valid(tv4)
`ifdef SHIFT_FILL_CNT_EN
    , .fill(fill4)
`endif
  );

  shift_pipe #(.WIDTH(4), .DEPTH(3)) u_p3 (
    .clk(clk), .reset(rst), .en(en), .flush(flush), .din(din[3:0]), .din_valid(din_valid),
    .tap_sel(tap_sel), .dout(dout3), .dout_valid(dv3), .tap_out(tap3), .tap_valid(tv3)
`ifdef SHIFT_FILL_CNT_EN
    , .fill(fill3)
`endif
  );

  shift_pipe #(.WIDTH(1), .DEPTH(2)) u_p2 (
    .clk(clk), .reset(rst), .en(1'b1), .flush(1'b0), .din(d2), .din_valid(1'b1),
    .tap_sel(tsel2), .dout(dout2), .dout_valid(dv2), .tap_out(tap2), .tap_valid(tv2)
`ifdef SHIFT_FILL_CNT_EN
    , .fill(fill2)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of accepted words, newest first; stage i is the i-th newest entry.
  logic [7:0] hd[$];
  bit         hv[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hd.delete();
      hv.delete();
    end else begin
      if (flush) foreach (hv[i]) hv[i] = 1'b0;
      if (en) begin
        hd.push_front(din);
        hv.push_front(flush ? 1'b0 : din_valid);
        if (hd.size() > 4) begin
          void'(hd.pop_back());
          void'(hv.pop_back());
        end
      end
    end
  end

  function automatic logic [7:0] mdat(input int i);
    return (i < hd.size()) ? hd[i] : 8'h00;
  endfunction

  function automatic logic mval(input int i);
    return (i < hv.size()) ? hv[i] : 1'b0;
  endfunction

  function automatic int mfill(input int depth);
    int c = 0;
    for (int i = 0; i < depth; i++) if (mval(i)) c++;
    return c;
  endfunction

  always @(negedge clk) begin
    chk("dout_d4", dout4, mdat(3));
    chk("dout_valid_d4", dv4, mval(3));
    chk("tap_out_d4", tap4, mdat(int'(tap_sel)));
    chk("tap_valid_d4", tv4, mval(int'(tap_sel)));
    chk("dout_d3", dout3, mdat(2) & 8'h0f);
    chk("dout_valid_d3", dv3, mval(2));
    chk("tap_out_d3", tap3, (tap_sel < 2'd3) ? (mdat(int'(tap_sel)) & 8'h0f) : 8'h00);
    chk("tap_valid_d3", tv3, (tap_sel < 2'd3) ? mval(int'(tap_sel)) : 1'b0);
`ifdef SHIFT_FILL_CNT_EN
    chk("fill_d4", fill4, mfill(4));
    chk("fill_d3", fill3, mfill(3));
`endif
  end

  task automatic tick(input logic e, input logic f, input logic [7:0] d, input logic v);
    en = e; flush = f; din = d; din_valid = v;
    @(posedge clk);
    #1;
  endtask

  logic       pat2 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       exp2 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] words[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] taps [4] = '{8'h88, 8'h77, 8'h66, 8'h55};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", dout4, 8'h00);
    chk("reset_dout_valid", dv4, 1'b0);
    chk("reset_tap_valid", tv4, 1'b0);
    rst = 1'b0;

    // Fill four valid words; the 2-stage 1-bit instance runs the legacy chain pattern alongside.
    for (int k = 0; k < 4; k++) begin
      d2 = pat2[k];
      tick(1'b1, 1'b0, words[k], 1'b1);
      chk("legacy_c", dout2, exp2[k]);
      chk("legacy_b", tap2, pat2[k]);
      if (k == 2) chk("lat_before_dout_valid", dv4, 1'b0);
    end
    chk("lat4_dout", dout4, 8'h11);
    chk("lat4_dout_valid", dv4, 1'b1);
`ifdef SHIFT_FILL_CNT_EN
    chk("fill_full", fill4, 3'd4);
`endif

    d2 = pat2[4];
    tick(1'b1, 1'b0, 8'h55, 1'b1);
    chk("legacy_c", dout2, exp2[4]);
    chk("after55_dout", dout4, 8'h22);

    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 8'hee, 1'b1);
      chk("stall_dout", dout4, 8'h22);
      chk("stall_tap", tap4, 8'h55);
    end
    tick(1'b1, 1'b0, 8'h66, 1'b1);
    tick(1'b1, 1'b0, 8'h77, 1'b1);
    chk("stall_pre_dout", dout4, 8'h44);
    tick(1'b1, 1'b0, 8'h88, 1'b1);
    chk("stall_lat_dout", dout4, 8'h55);

    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tap_sel = 2'(k);
      #1;
      chk("tap_sweep", tap4, taps[k]);
      chk("tap_sweep_valid", tv4, 1'b1);
    end
    tap_sel = 2'd3;
    #1;
    chk("tap_mirror_dout", tap4, dout4);
    chk("tap_oor_d3", tap3, 4'h0);
    chk("tap_oor_valid_d3", tv3, 1'b0);

    tap_sel = 2'd0;
    tick(1'b1, 1'b1, 8'haa, 1'b1);
    chk("flush_dout_shifts", dout4, 8'h66);
    chk("flush_dout_valid", dv4, 1'b0);
    chk("flush_tap", tap4, 8'haa);
    chk("flush_tap_valid", tv4, 1'b0);
`ifdef SHIFT_FILL_CNT_EN
    chk("flush_fill", fill4, 3'd0);
`endif

    tick(1'b1, 1'b0, 8'hb1, 1'b1);
    tick(1'b0, 1'b1, 8'hb2, 1'b1);
    chk("flush_hold_tap", tap4, 8'hb1);
    chk("flush_hold_tap_valid", tv4, 1'b0);
    chk("flush_hold_dout", dout4, 8'h77);

    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 8'hd1 + 8'(k), 1'b1);
    chk("refill_dout", dout4, 8'hd1);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout", dout4, 8'h00);
    chk("async_rst_dout_valid", dv4, 1'b0);
    chk("async_rst_tap", tap4, 8'h00);
    chk("async_rst_tap_valid", tv4, 1'b0);
`ifdef SHIFT_FILL_CNT_EN
    chk("async_rst_fill", fill4, 3'd0);
`endif
    #2 rst = 1'b0;

    tick(1'b1, 1'b0, 8'hc3, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_pending", dv4, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_dout", dout4, 8'hc3);
    chk("post_rst_dout_valid", dv4, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_drain", dv4, 1'b0);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
